// File: rtl/disp_pkg.sv
// disp_pkg: segment codes, digit index type and polarity constants for the seven-segment display path
package disp_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic       DP_ON     = 1'b0;
  localparam logic       DP_OFF    = 1'b1;
  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low {g,f,e,d,c,b,a}, dash for codes above 9
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: four-digit multiplexed seven-segment driver with per-frame digit snapshot,
// adjust-mode blink and colon dot
module time_display_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] H1,
  input  logic [3:0] H2,
  input  logic [2:0] M1,
  input  logic [3:0] M2,
  input  logic [2:0] S1,
  input  logic [3:0] S2,
  input  logic       show_sec,
  input  logic [3:0] blink_mask,
  input  logic       colon_en,
  input  logic       lz_blank,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  digit_idx_t      idx_q, idx_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            bphase_q, bphase_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic [3:0]      anode_d, digit;
  logic [6:0]      seg_d, seg_dec;
  logic            dp_d, tick, bwrap, blank;
  bcd_to_seg7 u_dec (.bcd_i(digit), .seg_o(seg_dec));
  // Digits are latched only at the frame boundary so a rollover never tears the shown value
  always_comb begin
    tick     = pcnt_q == PW'(REFRESH_DIV - 1);
    bwrap    = tick && bcnt_q == BW'(BLINK_TICKS - 1);
    pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
    idx_d    = tick ? idx_q + 1'b1 : idx_q;
    bcnt_d   = !tick ? bcnt_q : bwrap ? '0 : bcnt_q + 1'b1;
    bphase_d = bphase_q ^ bwrap;
    snap_d   = !(tick && idx_q == 2'd3) ? snap_q
             : show_sec ? {1'b0, M1, M2, 1'b0, S1, S2} : {2'b00, H1, H2, 1'b0, M1, M2};
    digit    = snap_q[idx_q];
    blank    = pcnt_q < PW'(BLANK_CYC) || (blink_mask[idx_q] && !bphase_q)
             || (lz_blank && idx_q == 2'd3 && digit == 4'd0);
    anode_d  = blank ? ANODE_OFF : ~(4'b0001 << idx_q);
    seg_d    = blank ? SEG_BLANK : seg_dec;
    dp_d     = !blank && idx_q == 2'd2 && colon_en && bphase_q ? DP_ON : DP_OFF;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      bphase_q <= 1'b1;
      snap_q   <= '0;
      anode    <= ANODE_OFF;
      seg      <= SEG_BLANK;
      dp       <= DP_OFF;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
      snap_q   <= snap_d;
      anode    <= anode_d;
      seg      <= seg_d;
      dp       <= dp_d;
    end
  end
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: cycle scoreboard plus directed spot checks for the display scanner
module tb_time_display_scan;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BT = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] H1 = '0;
  logic [3:0] H2 = '0;
  logic [2:0] M1 = '0;
  logic [3:0] M2 = '0;
  logic [2:0] S1 = '0;
  logic [3:0] S2 = '0;
  logic       show_sec = 1'b0;
  logic [3:0] blink_mask = '0;
  logic       colon_en = 1'b0;
  logic       lz_blank = 1'b0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  int checks = 0;
  int errors = 0;
  int pc, ix, bc;
  bit bph;
  logic [3:0] sn [4];
  logic [11:0] exp_q [$];
  time_display_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
    .show_sec(show_sec), .blink_mask(blink_mask), .colon_en(colon_en), .lz_blank(lz_blank),
    .anode(anode), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
    end
  endtask
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction
  task automatic mreset();
    pc = 0; ix = 0; bc = 0; bph = 1'b1;
    for (int i = 0; i < 4; i++) sn[i] = '0;
    exp_q.delete();
  endtask
  task automatic step();
    logic [3:0] d, a;
    bit blank;
    logic [11:0] e;
    d = sn[ix];
    blank = pc < BC || (blink_mask[ix] && !bph) || (lz_blank && ix == 3 && d == 0);
    a = 4'b0001 << ix;
    e = blank ? {4'hF, 7'h7F, 1'b1} : {~a, dec(d), !(ix == 2 && colon_en && bph)};
    exp_q.push_back(e);
    @(posedge clk);
    if (pc == RD - 1) begin
      if (ix == 3) begin
        sn[3] = show_sec ? {1'b0, M1} : {2'b0, H1};
        sn[2] = show_sec ? M2 : H2;
        sn[1] = show_sec ? {1'b0, S1} : {1'b0, M1};
        sn[0] = show_sec ? S2 : M2;
      end
      if (bc == BT - 1) begin bc = 0; bph = !bph; end else bc++;
      ix = (ix + 1) % 4;
      pc = 0;
    end else pc++;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("scan", {4'h0, anode, seg, dp}, {4'h0, e});
  endtask
  task automatic go(input int k, input int p, input int ph);
    int n;
    n = 0;
    do begin step(); n++; end
    while (!(ix == k && pc == p && (ph < 0 || int'(bph) == ph)) && n < 400);
    if (n >= 400) chk("go_timeout", 16'(n), 16'(0));
  endtask
  initial begin
    H1 = 2'd1; H2 = 4'd2; M1 = 3'd3; M2 = 4'd4;
    repeat (2) @(negedge clk);
    chk("reset_out", {4'h0, anode, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
    mreset();
    rst = 1'b1;
    go(3, 3, -1);
    chk("pre_snap_d3", {5'h0, anode, seg}, {5'h0, 4'b0111, 7'b1000000});
    go(0, 1, -1);
    chk("slot_blank", {12'h0, anode}, {12'h0, 4'hF});
    go(0, 3, -1);
    chk("hhmm_d0", {5'h0, anode, seg}, {5'h0, 4'b1110, 7'b0011001});
    go(1, 3, -1);
    chk("hhmm_d1", {5'h0, anode, seg}, {5'h0, 4'b1101, 7'b0110000});
    go(2, 3, -1);
    chk("hhmm_d2", {5'h0, anode, seg}, {5'h0, 4'b1011, 7'b0100100});
    go(3, 3, -1);
    chk("hhmm_d3", {5'h0, anode, seg}, {5'h0, 4'b0111, 7'b1111001});
    M2 = 4'd9;
    go(0, 3, -1);
    chk("m2_nine", {9'h0, seg}, {9'h0, 7'b0010000});
    go(1, 1, -1);
    M1 = 3'd5; M2 = 4'd0;
    go(1, 5, -1);
    chk("tear_hold", {9'h0, seg}, {9'h0, 7'b0110000});
    go(0, 3, -1);
    chk("tear_new_d0", {9'h0, seg}, {9'h0, 7'b1000000});
    go(1, 3, -1);
    chk("tear_new_d1", {9'h0, seg}, {9'h0, 7'b0010010});
    blink_mask = 4'b0011; colon_en = 1'b1;
    go(0, 3, 0);
    chk("blink_off", {4'h0, anode, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
    go(2, 3, 0);
    chk("colon_off", {11'h0, anode, dp}, {11'h0, 4'b1011, 1'b1});
    go(0, 3, 1);
    chk("blink_on", {9'h0, anode[0], seg}, {9'h0, 1'b0, 7'b1000000});
    go(2, 3, 1);
    chk("colon_on", {11'h0, anode, dp}, {11'h0, 4'b1011, 1'b0});
    blink_mask = '0; colon_en = 1'b0;
    H1 = 2'd0; lz_blank = 1'b1; M2 = 4'd12;
    go(0, 3, -1);
    go(0, 3, -1);
    chk("dash", {5'h0, anode, seg}, {5'h0, 4'b1110, 7'b0111111});
    go(3, 3, -1);
    chk("lz_dark", {12'h0, anode}, {12'h0, 4'hF});
    lz_blank = 1'b0; S1 = 3'd4; S2 = 4'd7;
    go(1, 2, -1);
    show_sec = 1'b1;
    go(2, 3, -1);
    chk("mode_old", {9'h0, seg}, {9'h0, 7'b0100100});
    go(0, 3, -1);
    chk("mode_s2", {9'h0, seg}, {9'h0, 7'b1111000});
    go(1, 3, -1);
    chk("mode_s1", {9'h0, seg}, {9'h0, 7'b0011001});
    go(3, 3, -1);
    chk("mode_m1", {9'h0, seg}, {9'h0, 7'b0010010});
    go(1, 4, -1);
    rst = 1'b0;
    #1;
    chk("async_rst", {4'h0, anode, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
    mreset();
    @(negedge clk);
    chk("rst_hold", {4'h0, anode, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
    rst = 1'b1;
    go(3, 3, -1);
    chk("post_rst_d3", {5'h0, anode, seg}, {5'h0, 4'b0111, 7'b1000000});
    go(0, 3, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
